// File: rtl/jf_pkg.sv
// Shared constants for the Juno First ROM loader: region map, chip-select bit positions, FSM states.
// Latency: n/a (package).
// Backpressure: n/a (package).
package jf_pkg;

    // Expected byte counts per download index.
    localparam logic [24:0] MAIN_SIZE_DFLT = 25'h12000;
    localparam logic [24:0] SND_SIZE_DFLT  = 25'h02000;

    // Main-board map on index 0.
    localparam logic [24:0] PROG_BASE    = 25'h00000;  // prog_rom1..3, 8 KB each
    localparam logic [24:0] BANK_BASE    = 25'h06000;  // bank0..5, 4 KB each
    localparam logic [24:0] BLIT_BASE    = 25'h0C000;  // blit0..2, 8 KB each
    localparam logic [24:0] MAIN_MAP_END = 25'h12000;

    // Sound-board map on index 1.
    localparam logic [24:0] SND_MAP_END  = 25'h02000;  // ep7, 8 KB

    // Download stream indices.
    localparam logic [7:0] IDX_MAIN = 8'd0;
    localparam logic [7:0] IDX_SND  = 8'd1;

    // rom_cs bit positions.
    localparam int         CS_W     = 13;
    localparam logic [3:0] CS_PROG0 = 4'd0;
    localparam logic [3:0] CS_BANK0 = 4'd3;
    localparam logic [3:0] CS_BLIT0 = 4'd9;
    localparam logic [3:0] CS_EP7   = 4'd12;

    // Per-index byte counters and the post-download settle window.
    localparam int         CNT_W      = 18;
    localparam logic [3:0] FLUSH_LAST = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_READY
    } ld_state_t;

    function automatic logic [CS_W-1:0] cs_onehot(input logic [3:0] sel);
        return {{(CS_W-1){1'b0}}, 1'b1} << sel;
    endfunction

endpackage

// File: rtl/jf_region_decode.sv
// Maps (stream index, byte address) to a one-hot ROM select, a region-local offset and an in-range flag.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   index    - ioctl stream index (0 main board, 1 sound board, others invalid)
//   addr     - byte address within that stream
//   cs       - one-hot select, all zero when out of range
//   offset   - address minus the base of the selected region
//   in_range - address lies below both the index size and the end of the map
module jf_region_decode
    import jf_pkg::*;
#(
    parameter logic [24:0] MAIN_SIZE = MAIN_SIZE_DFLT,
    parameter logic [24:0] SND_SIZE  = SND_SIZE_DFLT
) (
    input  logic [7:0]      index,
    input  logic [24:0]     addr,
    output logic [CS_W-1:0] cs,
    output logic [15:0]     offset,
    output logic            in_range
);

    logic [24:0] rel;
    logic [3:0]  sel;
    // Every region is at most 8 KB, so the top bits of the relative address never matter.
    logic [9:0]  unused_rel_hi;

    assign unused_rel_hi = rel[24:15];

    always_comb begin
        rel      = '0;
        sel      = '0;
        cs       = '0;
        offset   = '0;
        in_range = 1'b0;

        // A size larger than the map cannot make an unmapped address valid.
        if (index == IDX_MAIN && addr < MAIN_SIZE && addr < MAIN_MAP_END) begin
            in_range = 1'b1;
            if (addr < BANK_BASE) begin
                rel    = addr - PROG_BASE;
                sel    = CS_PROG0 + {2'b00, rel[14:13]};
                offset = {3'b000, rel[12:0]};
            end else if (addr < BLIT_BASE) begin
                rel    = addr - BANK_BASE;
                sel    = CS_BANK0 + {1'b0, rel[14:12]};
                offset = {4'h0, rel[11:0]};
            end else begin
                rel    = addr - BLIT_BASE;
                sel    = CS_BLIT0 + {2'b00, rel[14:13]};
                offset = {3'b000, rel[12:0]};
            end
            cs = cs_onehot(sel);
        end else if (index == IDX_SND && addr < SND_SIZE && addr < SND_MAP_END) begin
            in_range = 1'b1;
            offset   = {3'b000, addr[12:0]};
            cs       = cs_onehot(CS_EP7);
        end
    end

endmodule

// File: rtl/jf_rom_loader.sv
// Download sequencer: decodes ioctl writes into one-cycle ROM write strobes and gates core reset.
// Latency: a write strobe rise sampled at edge N is presented on the ROM ports for cycle N+1 only.
// Backpressure: none; the host paces writes, and downloads restarted during the flush window are ignored.
//
// Ports:
//   clk_49m, reset          - system clock and synchronous active-high reset
//   ioctl_download/index/addr/data/wr - MiSTer download stream
//   rom_addr, rom_data, rom_cs        - region-local address, byte and one-hot select (held between writes)
//   rom_wr_main, rom_wr_snd           - one-cycle write strobes for index 0 / index 1
//   core_reset, load_done, load_err   - core reset, both regions complete, sticky overrun/bad-index flag
module jf_rom_loader
    import jf_pkg::*;
#(
    parameter logic [24:0] MAIN_SIZE = MAIN_SIZE_DFLT,
    parameter logic [24:0] SND_SIZE  = SND_SIZE_DFLT
) (
    input  logic            clk_49m,
    input  logic            reset,
    input  logic            ioctl_download,
    input  logic [7:0]      ioctl_index,
    input  logic [24:0]     ioctl_addr,
    input  logic [7:0]      ioctl_data,
    input  logic            ioctl_wr,
    output logic [15:0]     rom_addr,
    output logic [7:0]      rom_data,
    output logic            rom_wr_main,
    output logic            rom_wr_snd,
    output logic [CS_W-1:0] rom_cs,
    output logic            core_reset,
    output logic            load_done,
    output logic            load_err
);

    localparam logic [CNT_W-1:0] MAIN_LIM = MAIN_SIZE[CNT_W-1:0];
    localparam logic [CNT_W-1:0] SND_LIM  = SND_SIZE[CNT_W-1:0];

    ld_state_t        state_q;
    ld_state_t        state_d;
    logic [3:0]       flush_q;
    logic             dl_q;
    logic             wr_q;
    logic [CNT_W-1:0] main_cnt;
    logic [CNT_W-1:0] snd_cnt;

    logic [CS_W-1:0]  dec_cs;
    logic [15:0]      dec_off;
    logic             dec_ok;

    logic             dl_rise;
    logic             dl_fall;
    logic             wr_rise;
    logic             wr_take;
    logic             accept;
    logic             reject;
    logic             start;
    logic             idx_main;
    logic             idx_snd;
    logic             main_full;
    logic             snd_full;

    jf_region_decode #(
        .MAIN_SIZE (MAIN_SIZE),
        .SND_SIZE  (SND_SIZE)
    ) u_decode (
        .index    (ioctl_index),
        .addr     (ioctl_addr),
        .cs       (dec_cs),
        .offset   (dec_off),
        .in_range (dec_ok)
    );

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    // Only the leading edge counts, so a host holding ioctl_wr for several cycles writes once.
    assign wr_rise   = ioctl_wr & ~wr_q;
    // A write rising in the same cycle download falls is still taken: state is LOAD on that edge.
    assign wr_take   = (state_q == ST_LOAD) & wr_rise;
    assign accept    = wr_take & dec_ok;
    assign reject    = wr_take & ~dec_ok;
    assign start     = dl_rise & ((state_q == ST_IDLE) | (state_q == ST_READY));
    assign idx_main  = (ioctl_index == IDX_MAIN);
    assign idx_snd   = (ioctl_index == IDX_SND);
    assign main_full = (main_cnt == MAIN_LIM);
    assign snd_full  = (snd_cnt == SND_LIM);

    always_comb begin
        state_d    = state_q;
        load_done  = 1'b0;
        core_reset = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (dl_rise) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (dl_fall) state_d = ST_FLUSH;
            end
            // Download edges are deliberately not looked at while flushing.
            ST_FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = (main_full && snd_full) ? ST_READY : ST_IDLE;
                end
            end
            ST_READY: begin
                load_done = 1'b1;
                if (dl_rise) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset reaches the core without waiting for the state register.
        core_reset = reset | (state_q != ST_READY);
    end

    always_ff @(posedge clk_49m) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            flush_q     <= '0;
            dl_q        <= 1'b0;
            wr_q        <= 1'b0;
            main_cnt    <= '0;
            snd_cnt     <= '0;
            rom_addr    <= '0;
            rom_data    <= '0;
            rom_cs      <= '0;
            rom_wr_main <= 1'b0;
            rom_wr_snd  <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state_q <= state_d;
            dl_q    <= ioctl_download;
            wr_q    <= ioctl_wr;
            // Counts cycles spent in FLUSH; zero on the edge that enters it.
            flush_q <= (state_q == ST_FLUSH) ? flush_q + 4'd1 : 4'd0;

            rom_wr_main <= accept & idx_main;
            rom_wr_snd  <= accept & idx_snd;

            if (accept) begin
                rom_cs   <= dec_cs;
                rom_addr <= dec_off;
                rom_data <= ioctl_data;
            end else if (reject) begin
                // A rejected write must not leave a stale select pointing at a ROM.
                rom_cs <= '0;
            end

            if (reject) load_err <= 1'b1;

            // start and accept are exclusive: start needs IDLE/READY, accept needs LOAD.
            if (start && idx_main) begin
                main_cnt <= '0;
            end else if (accept && idx_main && !main_full) begin
                main_cnt <= main_cnt + 1'b1;
            end

            if (start && idx_snd) begin
                snd_cnt <= '0;
            end else if (accept && idx_snd && !snd_full) begin
                snd_cnt <= snd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_jf_rom_loader.sv
// Randomized scoreboard bench for jf_rom_loader: two instances (full-size and reduced-size limits) share one stream.
// Latency: expected writes are queued at issue and popped when a write strobe appears one cycle later.
// Backpressure: none; stimulus is host-paced.
module tb_jf_rom_loader;
    import jf_pkg::*;

    localparam int A_MAIN = 'h12000;
    localparam int A_SND  = 'h2000;
    localparam int S_MAIN = 'h400;
    localparam int S_SND  = 'h100;

    logic        clk_49m = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;

    logic [15:0] a_rom_addr, s_rom_addr;
    logic [7:0]  a_rom_data, s_rom_data;
    logic        a_rom_wr_main, s_rom_wr_main, a_rom_wr_snd, s_rom_wr_snd;
    logic [12:0] a_rom_cs, s_rom_cs;
    logic        a_core_reset, s_core_reset, a_load_done, s_load_done, a_load_err, s_load_err;

    always #5 clk_49m = ~clk_49m;

    jf_rom_loader #(.MAIN_SIZE(25'(A_MAIN)), .SND_SIZE(25'(A_SND))) dut_a (
        .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .rom_addr(a_rom_addr), .rom_data(a_rom_data),
        .rom_wr_main(a_rom_wr_main), .rom_wr_snd(a_rom_wr_snd), .rom_cs(a_rom_cs),
        .core_reset(a_core_reset), .load_done(a_load_done), .load_err(a_load_err));

    jf_rom_loader #(.MAIN_SIZE(25'(S_MAIN)), .SND_SIZE(25'(S_SND))) dut_s (
        .clk_49m(clk_49m), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data),
        .ioctl_wr(ioctl_wr), .rom_addr(s_rom_addr), .rom_data(s_rom_data),
        .rom_wr_main(s_rom_wr_main), .rom_wr_snd(s_rom_wr_snd), .rom_cs(s_rom_cs),
        .core_reset(s_core_reset), .load_done(s_load_done), .load_err(s_load_err));

    typedef struct packed {
        logic        snd;
        logic [12:0] cs;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    wr_t q_a[$];
    wr_t q_s[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  pulses_a   = 0;
    int  pulses_s   = 0;
    int  msz[2]     = '{A_MAIN, S_MAIN};
    int  ssz[2]     = '{A_SND, S_SND};
    int  cnt_m[2]   = '{0, 0};
    int  cnt_s[2]   = '{0, 0};
    bit  err[2]     = '{1'b0, 1'b0};
    bit  in_load    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory map written out as plain arithmetic on byte addresses.
    function automatic void model(input logic [7:0] idx, input int addr, input int mlim, input int slim,
                                  output bit ok, output logic [12:0] cs, output logic [15:0] off);
        ok = 1'b0; cs = '0; off = '0;
        if (idx == 8'd0 && addr < mlim && addr < 'h12000) begin
            ok = 1'b1;
            if (addr < 'h6000) begin
                cs  = 13'd1 << (addr / 'h2000);
                off = 16'(addr % 'h2000);
            end else if (addr < 'hC000) begin
                cs  = 13'd1 << (3 + (addr - 'h6000) / 'h1000);
                off = 16'((addr - 'h6000) % 'h1000);
            end else begin
                cs  = 13'd1 << (9 + (addr - 'hC000) / 'h2000);
                off = 16'((addr - 'hC000) % 'h2000);
            end
        end else if (idx == 8'd1 && addr < slim && addr < 'h2000) begin
            ok  = 1'b1;
            cs  = 13'h1000;
            off = 16'(addr);
        end
    endfunction

    task automatic expect_wr(input int d, input logic [7:0] idx, input int addr, input logic [7:0] data);
        bit ok; logic [12:0] cs; logic [15:0] off; wr_t e;
        model(idx, addr, msz[d], ssz[d], ok, cs, off);
        if (!ok) begin
            err[d] = 1'b1;
            return;
        end
        e = '{snd: (idx == 8'd1), cs: cs, addr: off, data: data};
        if (d == 0) q_a.push_back(e); else q_s.push_back(e);
        if (idx == 8'd0 && cnt_m[d] < msz[d]) cnt_m[d]++;
        if (idx == 8'd1 && cnt_s[d] < ssz[d]) cnt_s[d]++;
    endtask

    task automatic mon(input int d, input logic [38:0] got);
        wr_t e;
        if (d == 0) begin
            pulses_a++;
            if (q_a.size() == 0) begin check("a_unexpected_pulse", 64'(got), 64'h0); return; end
            e = q_a.pop_front();
        end else begin
            pulses_s++;
            if (q_s.size() == 0) begin check("s_unexpected_pulse", 64'(got), 64'h0); return; end
            e = q_s.pop_front();
        end
        check(d == 0 ? "a_write" : "s_write", 64'(got), 64'({~e.snd, e.snd, e.cs, e.addr, e.data}));
    endtask

    always @(negedge clk_49m) begin
        if (a_rom_wr_main || a_rom_wr_snd)
            mon(0, {a_rom_wr_main, a_rom_wr_snd, a_rom_cs, a_rom_addr, a_rom_data});
        if (s_rom_wr_main || s_rom_wr_snd)
            mon(1, {s_rom_wr_main, s_rom_wr_snd, s_rom_cs, s_rom_addr, s_rom_data});
    end

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_49m);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        in_load        = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (idx == 8'd0) cnt_m[d] = 0;
            if (idx == 8'd1) cnt_s[d] = 0;
        end
    endtask

    // drop=1 lowers ioctl_download in the same cycle as the write rise; the caller then runs flush_check.
    task automatic do_wr(input logic [7:0] idx, input int addr, input logic [7:0] data, input int hold, input bit drop);
        @(negedge clk_49m);
        ioctl_index = idx;
        ioctl_addr  = 25'(addr);
        ioctl_data  = data;
        ioctl_wr    = 1'b1;
        if (in_load) for (int d = 0; d < 2; d++) expect_wr(d, idx, addr, data);
        if (drop) begin
            ioctl_download = 1'b0;
            in_load        = 1'b0;
        end else begin
            repeat (hold) @(negedge clk_49m);
            ioctl_wr = 1'b0;
            #1;
        end
    endtask

    // Entered on the negedge where ioctl_download was lowered.
    task automatic flush_check(input string tag);
        bit done_a, done_s;
        @(negedge clk_49m);
        ioctl_wr = 1'b0;
        repeat (15) @(negedge clk_49m);
        check({tag, "_a_done_early"}, a_load_done, 0);
        check({tag, "_s_done_early"}, s_load_done, 0);
        @(negedge clk_49m);
        done_a = (cnt_m[0] >= msz[0]) && (cnt_s[0] >= ssz[0]);
        done_s = (cnt_m[1] >= msz[1]) && (cnt_s[1] >= ssz[1]);
        check({tag, "_a_done"},   a_load_done, done_a);
        check({tag, "_s_done"},   s_load_done, done_s);
        check({tag, "_a_corerst"}, a_core_reset, !done_a);
        check({tag, "_s_corerst"}, s_core_reset, !done_s);
        check({tag, "_a_err"},    a_load_err, err[0]);
        check({tag, "_s_err"},    s_load_err, err[1]);
        check({tag, "_a_drained"}, q_a.size(), 0);
        check({tag, "_s_drained"}, q_s.size(), 0);
    endtask

    task automatic end_dl(input string tag);
        @(negedge clk_49m);
        ioctl_download = 1'b0;
        in_load        = 1'b0;
        flush_check(tag);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_a_outs"}, {a_rom_addr, a_rom_data, a_rom_cs, a_rom_wr_main, a_rom_wr_snd, a_load_done, a_load_err}, 0);
        check({tag, "_s_outs"}, {s_rom_addr, s_rom_data, s_rom_cs, s_rom_wr_main, s_rom_wr_snd, s_load_done, s_load_err}, 0);
        check({tag, "_a_corerst"}, a_core_reset, 1);
        check({tag, "_s_corerst"}, s_core_reset, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int pa, ps;
        int edges[6] = '{'h5FFF, 'h6000, 'hBFFF, 'hC001, 'h11FFF, 'h3FF};
        reset = 1'b1; ioctl_download = 1'b0; ioctl_index = '0;
        ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
        repeat (3) @(negedge clk_49m);
        chk_reset("reset");
        reset = 1'b0;

        // Held strobe: one pulse only.
        start_dl(8'd0);
        pa = pulses_a;
        do_wr(8'd0, 'h6123, 8'hA5, 4, 0);
        check("hold_pulses", pulses_a - pa, 1);
        check("hold_cs", a_rom_cs, 13'h0008);
        check("hold_addr", a_rom_addr, 16'h0123);
        check("hold_data", a_rom_data, 8'hA5);

        do_wr(8'd0, 'hC000, 8'h3C, 1, 0);
        check("blit0_cs", a_rom_cs, 13'h0200);
        check("blit0_addr", a_rom_addr, 16'h0000);

        foreach (edges[i]) do_wr(8'd0, edges[i], 8'($urandom), 1, 0);
        for (int i = 0; i < 200; i++)
            do_wr(8'd0, int'($urandom_range(0, 'h11FFF)), 8'($urandom), int'($urandom_range(1, 3)), 0);

        // Overrun and unknown index: no pulses, error flag, still loading.
        pa = pulses_a; ps = pulses_s;
        do_wr(8'd0, 'h12000, 8'h11, 1, 0);
        do_wr(8'd2, 'h100, 8'h22, 1, 0);
        @(negedge clk_49m); #1;
        check("err_no_pulse_a", pulses_a - pa, 0);
        check("err_no_pulse_s", pulses_s - ps, 0);
        check("err_cs_cleared", a_rom_cs, 0);
        check("err_flag_a", a_load_err, 1);
        do_wr(8'd0, 'h10, 8'h5A, 1, 0);
        check("still_load_pulse", pulses_a - pa, 1);
        end_dl("idx0_only");

        // Sound index with boundary overrun.
        start_dl(8'd1);
        for (int i = 0; i < 100; i++)
            do_wr(8'd1, int'($urandom_range(0, 'h1FFF)), 8'($urandom), 1, 0);
        do_wr(8'd1, 'h1FFF, 8'h77, 2, 0);
        do_wr(8'd1, 'h2000, 8'h88, 1, 0);
        end_dl("idx1");

        // Reset in the same cycle as a write rise mid-stream.
        start_dl(8'd0);
        for (int i = 0; i < 5; i++) do_wr(8'd0, i, 8'($urandom), 1, 0);
        @(negedge clk_49m);
        ioctl_addr = 25'h5; ioctl_data = 8'hEE; ioctl_wr = 1'b1; reset = 1'b1;
        in_load = 1'b0;
        @(negedge clk_49m); #1;
        chk_reset("midreset");
        reset = 1'b0; ioctl_wr = 1'b0; ioctl_download = 1'b0;
        for (int d = 0; d < 2; d++) begin cnt_m[d] = 0; cnt_s[d] = 0; err[d] = 1'b0; end
        repeat (2) @(negedge clk_49m);

        // Full reduced-size main stream, then sound stream ending with a coincident fall.
        pa = pulses_a; ps = pulses_s;
        start_dl(8'd0);
        for (int i = 0; i < S_MAIN; i++) do_wr(8'd0, i, 8'($urandom), 1, 0);
        end_dl("full_main");
        start_dl(8'd1);
        for (int i = 0; i < S_SND - 1; i++) do_wr(8'd1, i, 8'($urandom), 1, 0);
        do_wr(8'd1, S_SND - 1, 8'hC3, 1, 1);
        flush_check("full_snd");
        check("full_pulses_s", pulses_s - ps, S_MAIN + S_SND);
        check("full_pulses_a", pulses_a - pa, S_MAIN + S_SND);
        check("last_write_data", s_rom_data, 8'hC3);
        check("ready_s", s_load_done, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
